// File: rtl/mem_rd_arbiter_if.sv
// Bundle for the shared MMU read port: requester A/B read channels, the MMU data-read
// channel, pipeline flush and the timeout flag. slave = arbiter side, master = environment.
interface mem_rd_arbiter_if;
  logic        FLUSH;
  logic        A_RDEN;
  logic [31:0] A_RIADDR;
  logic        A_RVALID;
  logic [31:0] A_ROADDR;
  logic [31:0] A_RDATA;
  logic        A_WAIT;
  logic        B_RDEN;
  logic [31:0] B_RIADDR;
  logic        B_RVALID;
  logic [31:0] B_ROADDR;
  logic [31:0] B_RDATA;
  logic        B_WAIT;
  logic        DATA_RDEN;
  logic [31:0] DATA_RIADDR;
  logic [31:0] DATA_ROADDR;
  logic        DATA_RVALID;
  logic [31:0] DATA_RDATA;
  logic        TIMEOUT_ERR;

  modport slave (
    input  FLUSH,
    input  A_RDEN, A_RIADDR, B_RDEN, B_RIADDR,
    output A_RVALID, A_ROADDR, A_RDATA, A_WAIT,
    output B_RVALID, B_ROADDR, B_RDATA, B_WAIT,
    output DATA_RDEN, DATA_RIADDR,
    input  DATA_ROADDR, DATA_RVALID, DATA_RDATA,
    output TIMEOUT_ERR
  );

  modport master (
    output FLUSH,
    output A_RDEN, A_RIADDR, B_RDEN, B_RIADDR,
    input  A_RVALID, A_ROADDR, A_RDATA, A_WAIT,
    input  B_RVALID, B_ROADDR, B_RDATA, B_WAIT,
    input  DATA_RDEN, DATA_RIADDR,
    output DATA_ROADDR, DATA_RVALID, DATA_RDATA,
    input  TIMEOUT_ERR
  );
endinterface

// File: rtl/mem_rd_arbiter.sv
// Two-requester arbiter for the single MMU data-read port, one read in flight at a time.
// Optional REQ-state timeout abort is compiled in with `define MEM_RD_ARB_TIMEOUT_EN.
module mem_rd_arbiter #(
  parameter bit PRIO_INIT      = 1'b0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             CLK,
  input  logic             RST,
  mem_rd_arbiter_if.slave  bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;   // 0: A, 1: B
  logic        rr_q, rr_d;         // side that wins the next tie
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        resp_ok;

`ifdef MEM_RD_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rr_q    <= PRIO_INIT;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef MEM_RD_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef MEM_RD_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef MEM_RD_ARB_TIMEOUT_EN
    cnt_d   = (state_q == REQ) ? cnt_q + 1'b1 : '0;
    to_d    = to_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.A_RDEN || bus.B_RDEN) begin
          owner_d = (bus.A_RDEN && bus.B_RDEN) ? rr_q : bus.B_RDEN;
          addr_d  = owner_d ? bus.B_RIADDR : bus.A_RIADDR;
          state_d = REQ;
`ifdef MEM_RD_ARB_TIMEOUT_EN
          to_d    = 1'b0;
`endif
        end
      end
      REQ: begin
        // Responses tagged for some other address belong to an earlier, aborted read.
        if (bus.DATA_RVALID && bus.DATA_ROADDR == addr_q) begin
          data_d  = bus.DATA_RDATA;
          state_d = RESP;
        end
`ifdef MEM_RD_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          data_d  = '0;
          to_d    = 1'b1;
          state_d = RESP;
        end
`endif
      end
      RESP: begin
        rr_d    = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flush abandons the transaction without touching arbitration history.
    if (bus.FLUSH) begin
      state_d = IDLE;
      owner_d = owner_q;
      rr_d    = rr_q;
      addr_d  = addr_q;
      data_d  = data_q;
    end
  end

  assign resp_ok         = (state_q == RESP) && !bus.FLUSH;

  assign bus.A_RVALID    = resp_ok && !owner_q;
  assign bus.A_ROADDR    = bus.A_RVALID ? addr_q : '0;
  assign bus.A_RDATA     = bus.A_RVALID ? data_q : '0;
  assign bus.A_WAIT      = bus.A_RDEN && !bus.A_RVALID;

  assign bus.B_RVALID    = resp_ok && owner_q;
  assign bus.B_ROADDR    = bus.B_RVALID ? addr_q : '0;
  assign bus.B_RDATA     = bus.B_RVALID ? data_q : '0;
  assign bus.B_WAIT      = bus.B_RDEN && !bus.B_RVALID;

  assign bus.DATA_RDEN   = (state_q == REQ);
  assign bus.DATA_RIADDR = bus.DATA_RDEN ? addr_q : '0;

`ifdef MEM_RD_ARB_TIMEOUT_EN
  assign bus.TIMEOUT_ERR = resp_ok && to_q;
`else
  assign bus.TIMEOUT_ERR = 1'b0;
`endif

endmodule
